window3x3_stream: RTL



---
 rtl/vision_pkg.sv | 25 ++
 rtl/linebuf_ram.sv | 31 +++
 rtl/window3x3_stream.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vision_pkg.sv
`default_nettype none
// ============================================================================
// vision_pkg : frame geometry defaults and 3x3 window tap indices
// Rev 1.0
// ============================================================================
package vision_pkg;

  localparam int COLS_DEFAULT  = 640;
  localparam int ROWS_DEFAULT  = 480;
  localparam int PIX_W_DEFAULT = 8;

  // Tap k of a window occupies bits [k*PIX_W +: PIX_W]; Z4 is the centre.
  localparam int Z0 = 0;
  localparam int Z1 = 1;
  localparam int Z2 = 2;
  localparam int Z3 = 3;
  localparam int Z4 = 4;
  localparam int Z5 = 5;
  localparam int Z6 = 6;
  localparam int Z7 = 7;
  localparam int Z8 = 8;
  localparam int TAPS = 9;

endpackage
`default_nettype wire

// File: rtl/linebuf_ram.sv
`default_nettype none
// ============================================================================
// linebuf_ram : single-port line memory, asynchronous read, synchronous write
// Rev 1.0
// ============================================================================
module linebuf_ram
  import vision_pkg::*;
#(
  parameter int DEPTH = COLS_DEFAULT,
  parameter int WIDTH = 2 * PIX_W_DEFAULT
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  // Contents are deliberately unreset so the array maps to distributed RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/window3x3_stream.sv
`default_nettype none
// ============================================================================
// window3x3_stream : raster pixel stream to registered 3x3 neighbourhoods
// Rev 1.0
// ============================================================================
module window3x3_stream
  import vision_pkg::*;
#(
  parameter int COLS  = COLS_DEFAULT,
  parameter int ROWS  = ROWS_DEFAULT,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [PIX_W-1:0]        in_data,
  output logic                    out_valid,
  output logic [TAPS*PIX_W-1:0]   out_window,
  output logic [$clog2(COLS)-1:0] out_x,
  output logic [$clog2(ROWS)-1:0] out_y,
  output logic                    out_eof
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int RW = 3 * PIX_W;

  logic [XW-1:0]         x_q, x_d, cur_x;
  logic [YW-1:0]         y_q, y_d, cur_y;
  logic [RW-1:0]         row2_q, row2_d, row1_q, row1_d, row0_q, row0_d;
  logic                  out_valid_q, out_valid_d, out_eof_q, out_eof_d;
  logic [TAPS*PIX_W-1:0] win_q, win_d;
  logic [XW-1:0]         ox_q, ox_d;
  logic [YW-1:0]         oy_q, oy_d;
  logic [2*PIX_W-1:0]    lb_rd, lb_wr;
  logic [PIX_W-1:0]      lb1_rd, lb2_rd;
  logic                  last_col, last_row, emit;

  // lb1 (row y-1) sits in the low half, lb2 (row y-2) in the high half.
  linebuf_ram #(
    .DEPTH (COLS),
    .WIDTH (2 * PIX_W)
  ) u_linebuf (
    .clock (clock),
    .we    (in_valid),
    .addr  (cur_x),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  always_comb begin
    cur_x    = in_sof ? '0 : x_q;
    cur_y    = in_sof ? '0 : y_q;
    lb1_rd   = lb_rd[PIX_W-1:0];
    lb2_rd   = lb_rd[2*PIX_W-1:PIX_W];
    lb_wr    = {lb1_rd, in_data};
    last_col = (cur_x == XW'(COLS - 1));
    last_row = (cur_y == YW'(ROWS - 1));
    emit     = in_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));

    x_d         = x_q;
    y_d         = y_q;
    row2_d      = row2_q;
    row1_d      = row1_q;
    row0_d      = row0_q;
    win_d       = win_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    out_valid_d = emit;
    out_eof_d   = emit && last_col && last_row;

    if (in_valid) begin
      x_d    = last_col ? '0 : cur_x + XW'(1);
      y_d    = last_col ? (last_row ? '0 : cur_y + YW'(1)) : cur_y;
      row2_d = {row2_q[RW-PIX_W-1:0], lb2_rd};
      row1_d = {row1_q[RW-PIX_W-1:0], lb1_rd};
      row0_d = {row0_q[RW-PIX_W-1:0], in_data};
    end

    // Window and centre only update on emission so they hold between windows.
    if (emit) begin
      win_d = {row2_d, row1_d, row0_d};
      ox_d  = cur_x - XW'(1);
      oy_d  = cur_y - YW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      row2_q      <= '0;
      row1_q      <= '0;
      row0_q      <= '0;
      win_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      row2_q      <= row2_d;
      row1_q      <= row1_d;
      row0_q      <= row0_d;
      win_q       <= win_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = win_q;
  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign out_eof    = out_eof_q;

endmodule
`default_nettype wire
